// File: rtl/ice_echo_int_pkg.sv
// Shared types and constants for the ICE echo slave and its payload FIFO.
package ice_echo_int_pkg;

    localparam int SL_ADDR_W = 9;
    localparam int SL_DATA_W = 9;

    // Controller FSM states; exported unchanged on dbg_state.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SKIP     = 4'd1,
        ST_RECV     = 4'd2,
        ST_ARB      = 4'd3,
        ST_HDR_TYPE = 4'd4,
        ST_HDR_EID  = 4'd5,
        ST_HDR_LEN  = 4'd6,
        ST_PAYLOAD  = 4'd7,
        ST_COMMIT   = 4'd8
    } echo_state_e;

    // States that put a byte on the slave bus this cycle.
    function automatic logic is_write_state(input echo_state_e s);
        return (s == ST_HDR_TYPE) || (s == ST_HDR_EID) ||
               (s == ST_HDR_LEN)  || (s == ST_PAYLOAD);
    endfunction

    // States during which the slave bus request is held.
    function automatic logic holds_bus(input echo_state_e s);
        return (s == ST_ARB) || is_write_state(s) || (s == ST_COMMIT);
    endfunction

endpackage

// File: rtl/ice_echo_int_fifo.sv
// Synchronous 8-bit byte FIFO, first-word-fall-through read, with flush.
// Pushes while full and pops while empty are ignored; flush wins over push.
module ice_echo_int_fifo
    import ice_echo_int_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] wr_data,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
        rd_data = mem[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ice_echo_int.sv
// ICE echo slave: captures master-bus frames addressed to ECHO_ADDR, buffers
// the payload, then writes {RSP_TYPE, event_id, len, payload...} into the
// controller tx buffer over the shared tri-state slave bus and commits it.
//
// Slave bus handshake: sl_arb_request is held from ARB until the cycle after
// COMMIT (or an abort). The arbiter answers with sl_arb_grant and keeps it
// high while the request stays high. Grant is registered before use, so the
// first header byte appears two cycles after grant is first seen. Each cycle
// with sl_data[8]=1 is one byte write at sl_addr; sl_latch_tail is a one-cycle
// commit of everything written. sl_overflow during a write, or grant loss
// mid-tenure, abandons the response without commit.
module ice_echo_int
    import ice_echo_int_pkg::*;
#(
    parameter logic [7:0] ECHO_ADDR = 8'h65,
    parameter logic [7:0] RSP_TYPE  = 8'h45,
    parameter int         DEPTH     = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           ma_data,
    input  logic [7:0]           ma_addr,
    input  logic                 ma_data_valid,
    input  logic                 ma_frame_valid,
    input  logic                 sl_overflow,
    input  logic [SL_ADDR_W-1:0] sl_tail,
    output logic [SL_ADDR_W-1:0] sl_addr,
    output logic [SL_DATA_W-1:0] sl_data,
    output logic                 sl_latch_tail,
    output logic                 sl_arb_request,
    input  logic                 sl_arb_grant,
    output echo_state_e          dbg_state
);
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    echo_state_e          state_q, state_d;
    logic                 fv_q, fv_d;
    logic                 grant_q, grant_d;
    logic                 req_q, req_d;
    logic [SL_ADDR_W-1:0] wptr_q, wptr_d;
    logic [8:0]           len_q, len_d;
    logic [7:0]           eid_q, eid_d;

    logic                 frame_rise;
    logic                 accept_byte;
    logic                 abort;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_rd_data;
    logic                 wr_strobe;
    logic [7:0]           wr_byte;
    logic [SL_ADDR_W-1:0] bus_addr;
    logic                 latch_tail;
    logic                 drive_bus;

    ice_echo_int_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (ma_data),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, counters and bus outputs; abort overrides the normal flow.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        len_d      = len_q;
        eid_d      = eid_q;
        fv_d       = ma_frame_valid;
        grant_d    = sl_arb_grant;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        wr_strobe  = 1'b0;
        wr_byte    = 8'h00;
        bus_addr   = wptr_q;
        latch_tail = 1'b0;

        frame_rise  = ma_frame_valid && !fv_q;
        // A byte on the same cycle as the address match, or any byte while
        // receiving (including one coinciding with the frame's falling edge).
        accept_byte = ma_data_valid &&
                      ((state_q == ST_RECV) ||
                       ((state_q == ST_IDLE) && frame_rise && (ma_addr == ECHO_ADDR)));
        fifo_push   = accept_byte && !fifo_full;
        if (accept_byte && (len_q != DEPTH_L)) len_d = len_q + 9'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_rise) state_d = (ma_addr == ECHO_ADDR) ? ST_RECV : ST_SKIP;
            end
            ST_SKIP: begin
                if (!ma_frame_valid) state_d = ST_IDLE;
            end
            ST_RECV: begin
                if (!ma_frame_valid) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (grant_q) begin
                    wptr_d  = sl_tail;
                    state_d = ST_HDR_TYPE;
                end
            end
            ST_HDR_TYPE: begin
                wr_strobe = 1'b1;
                wr_byte   = RSP_TYPE;
                wptr_d    = wptr_q + 9'd1;
                state_d   = ST_HDR_EID;
            end
            ST_HDR_EID: begin
                wr_strobe = 1'b1;
                wr_byte   = eid_q;
                wptr_d    = wptr_q + 9'd1;
                state_d   = ST_HDR_LEN;
            end
            ST_HDR_LEN: begin
                wr_strobe = 1'b1;
                wr_byte   = len_q[7:0];
                wptr_d    = wptr_q + 9'd1;
                state_d   = (len_q == 9'd0) ? ST_COMMIT : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                wr_strobe = 1'b1;
                wr_byte   = fifo_rd_data;
                fifo_pop  = !fifo_empty;
                wptr_d    = wptr_q + 9'd1;
                len_d     = len_q - 9'd1;
                if (len_q == 9'd1) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                bus_addr   = wptr_q - 9'd1;
                latch_tail = sl_arb_grant;
                eid_d      = eid_q + 8'd1;
                len_d      = 9'd0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        abort = (is_write_state(state_q) && (sl_overflow || !sl_arb_grant)) ||
                ((state_q == ST_COMMIT) && !sl_arb_grant);
        if (abort) begin
            state_d    = ST_IDLE;
            fifo_pop   = 1'b0;
            fifo_flush = 1'b1;
            len_d      = 9'd0;
            eid_d      = eid_q;
            wptr_d     = wptr_q;
        end

        req_d = holds_bus(state_d);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fv_q    <= 1'b0;
            grant_q <= 1'b0;
            req_q   <= 1'b0;
            wptr_q  <= '0;
            len_q   <= 9'd0;
            eid_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            fv_q    <= fv_d;
            grant_q <= grant_d;
            req_q   <= req_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            eid_q   <= eid_d;
        end
    end

    // Request drops combinationally with reset; the bus is only driven while
    // both the request and the registered grant are up.
    assign sl_arb_request = req_q && !reset;
    assign drive_bus      = req_q && grant_q && !reset;
    assign sl_addr        = drive_bus ? bus_addr : {SL_ADDR_W{1'bz}};
    assign sl_data        = drive_bus ? {wr_strobe, wr_byte} : {SL_DATA_W{1'bz}};
    assign sl_latch_tail  = drive_bus ? latch_tail : 1'bz;
    assign dbg_state      = state_q;

endmodule
